// File: rtl/point_rr_arbiter.sv
// Two-source round-robin point arbiter with bounded bursts, one registered
// output stage and per-source accepted-beat counters.
module point_rr_arbiter #(
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [15:0]      a_point,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [15:0]      b_point,
  output logic             b_ready,
  output logic             o_valid,
  output logic [15:0]      o_point,
  output logic             o_src,
  input  logic             o_ready,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam int BC_W = $clog2(BURST + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  logic [1:0]      state;
  logic [BC_W-1:0] bcnt;
  logic            sel_a;
  logic            sel_b;
  logic            cont;
  logic            load;
  logic            xfer;

  // cont marks a grant that extends the owner's current burst; any other
  // grant (new owner or owner restarting because nobody else wants the bus)
  // begins a fresh burst.
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    cont  = 1'b0;
    case (state)
      OWN_A: begin
        if (a_valid && (bcnt < BC_W'(BURST))) begin
          sel_a = 1'b1;
          cont  = 1'b1;
        end else if (b_valid) begin
          sel_b = 1'b1;
        end else if (a_valid) begin
          sel_a = 1'b1;
        end
      end
      OWN_B: begin
        if (b_valid && (bcnt < BC_W'(BURST))) begin
          sel_b = 1'b1;
          cont  = 1'b1;
        end else if (a_valid) begin
          sel_a = 1'b1;
        end else if (b_valid) begin
          sel_b = 1'b1;
        end
      end
      default: begin
        if (a_valid) begin
          sel_a = 1'b1;
        end else if (b_valid) begin
          sel_b = 1'b1;
        end
      end
    endcase
  end

  assign load    = !o_valid || o_ready;
  assign a_ready = load && sel_a;
  assign b_ready = load && sel_b;
  assign xfer    = a_ready || b_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_point <= 16'h0000;
      o_src   <= 1'b0;
      state   <= IDLE;
      bcnt    <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_point <= sel_b ? b_point : a_point;
      o_src   <= sel_b;
      state   <= sel_b ? OWN_B : OWN_A;
      bcnt    <= cont ? bcnt + BC_W'(1) : BC_W'(1);
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

  // clr wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_ready) cnt_a <= cnt_a + CNT_W'(1);
      if (b_ready) cnt_b <= cnt_b + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_point_rr_arbiter.sv
// Directed bench for point_rr_arbiter: a reference arbitration model feeds a
// scoreboard of expected output beats, plus fixed expectations per scenario.
module tb_point_rr_arbiter;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, o_ready, clr;
  logic [15:0] a_point, b_point;

  logic        a_ready, b_ready, o_valid, o_src;
  logic [15:0] o_point, cnt_a, cnt_b;

  logic        a_ready4, b_ready4, o_valid4, o_src4;
  logic [15:0] o_point4;
  logic [3:0]  cnt_a4, cnt_b4;

  point_rr_arbiter #(.BURST(BURST), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_point(a_point), .a_ready(a_ready),
    .b_valid(b_valid), .b_point(b_point), .b_ready(b_ready),
    .o_valid(o_valid), .o_point(o_point), .o_src(o_src), .o_ready(o_ready),
    .clr(clr), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  point_rr_arbiter #(.BURST(BURST), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_point(a_point), .a_ready(a_ready4),
    .b_valid(b_valid), .b_point(b_point), .b_ready(b_ready4),
    .o_valid(o_valid4), .o_point(o_point4), .o_src(o_src4), .o_ready(o_ready),
    .clr(clr), .cnt_a(cnt_a4), .cnt_b(cnt_b4)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_owner, m_bcnt, m_sel, m_ca, m_cb;
  bit          m_cont, m_ov;
  logic [16:0] m_last;
  logic [16:0] sb_q[$];
  logic        seen_a_ready, seen_b_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_bcnt = 0; m_sel = 0; m_cont = 0; m_ov = 0;
    m_last = '0; m_ca = 0; m_cb = 0;
    sb_q.delete();
  endtask

  // One clock: grant decision checked mid-cycle, registered results checked after the edge.
  task automatic step();
    logic        ra, rb;
    logic [16:0] beat;
    @(negedge clk);
    m_sel = 0; m_cont = 0;
    case (m_owner)
      1: if (a_valid && m_bcnt < BURST) begin m_sel = 1; m_cont = 1; end
         else if (b_valid) m_sel = 2;
         else if (a_valid) m_sel = 1;
      2: if (b_valid && m_bcnt < BURST) begin m_sel = 2; m_cont = 1; end
         else if (a_valid) m_sel = 1;
         else if (b_valid) m_sel = 2;
      default: if (a_valid) m_sel = 1; else if (b_valid) m_sel = 2;
    endcase
    ra = (!m_ov || o_ready) && (m_sel == 1);
    rb = (!m_ov || o_ready) && (m_sel == 2);
    seen_a_ready = a_ready;
    seen_b_ready = b_ready;
    check("a_ready", 32'(a_ready), 32'(ra));
    check("b_ready", 32'(b_ready), 32'(rb));
    check("a_ready_w4", 32'(a_ready4), 32'(ra));
    check("b_ready_w4", 32'(b_ready4), 32'(rb));
    if (ra) sb_q.push_back({1'b0, a_point});
    if (rb) sb_q.push_back({1'b1, b_point});
    @(posedge clk); #1;
    if (ra || rb) begin
      beat    = sb_q.pop_front();
      m_ov    = 1;
      m_last  = beat;
      m_bcnt  = m_cont ? m_bcnt + 1 : 1;
      m_owner = m_sel;
    end else if (o_ready) begin
      m_ov = 0;
    end
    if (clr) begin
      m_ca = 0; m_cb = 0;
    end else begin
      if (ra) m_ca++;
      if (rb) m_cb++;
    end
    check("o_valid", 32'(o_valid), 32'(m_ov));
    check("o_valid_w4", 32'(o_valid4), 32'(m_ov));
    if (m_ov) begin
      check("o_point", 32'(o_point), 32'(m_last[15:0]));
      check("o_src", 32'(o_src), 32'(m_last[16]));
      check("o_point_w4", 32'(o_point4), 32'(m_last[15:0]));
      check("o_src_w4", 32'(o_src4), 32'(m_last[16]));
    end
    check("cnt_a", 32'(cnt_a), m_ca & 32'hFFFF);
    check("cnt_b", 32'(cnt_b), m_cb & 32'hFFFF);
    check("cnt_a_w4", 32'(cnt_a4), m_ca & 32'hF);
    check("cnt_b_w4", 32'(cnt_b4), m_cb & 32'hF);
    if (ra) a_point += 16'h0101;
    if (rb) b_point += 16'h0101;
  endtask

  initial begin
    int          exp2[12];
    int          exp5[8];
    int          n_acc;
    logic [16:0] hold;
    exp2 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    exp5 = '{1, 0, 0, 1, 1, 1, 1, 0};

    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; o_ready = 1'b1; clr = 1'b0;
    a_point = 16'h0101; b_point = 16'hF0F0;
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    check("init_o_valid", 32'(o_valid), 32'd0);
    check("init_o_point", 32'(o_point), 32'd0);

    // Reset pulse in the middle of traffic
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_point", 32'(o_point), 32'd0);
    check("rst_o_src", 32'(o_src), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    model_reset();
    a_point = 16'h0101; b_point = 16'hF0F0;

    // Both sources saturating: bursts of four alternate, first grant to A
    for (int i = 0; i < 12; i++) begin
      step();
      check("t2_src", 32'(o_src), 32'(exp2[i]));
      if (i == 0) check("t2_first_a", 32'(o_point), 32'h0101);
      if (i == 4) check("t2_first_b", 32'(o_point), 32'hF0F0);
    end

    // Only A valid: burst restarts without bubbles
    a_valid = 1'b0; b_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; a_valid = 1'b1;
    n_acc = 0;
    repeat (10) begin
      step();
      if (seen_a_ready) n_acc++;
    end
    check("t3_accepts", 32'(n_acc), 32'd10);
    check("t3_cnt_a", 32'(cnt_a), 32'd10);
    check("t3_cnt_b", 32'(cnt_b), 32'd0);

    // Output stall with both sources waiting
    b_valid = 1'b1; o_ready = 1'b0;
    hold = m_last;
    repeat (5) begin
      step();
      check("t4_a_ready", 32'(seen_a_ready), 32'd0);
      check("t4_b_ready", 32'(seen_b_ready), 32'd0);
      check("t4_hold_point", 32'(o_point), 32'(hold[15:0]));
      check("t4_hold_src", 32'(o_src), 32'(hold[16]));
    end
    o_ready = 1'b1;
    step();
    check("t4_release_src", 32'(o_src), 32'd0);

    // Owner A drops out after two beats; B then gets a full burst
    a_valid = 1'b0; b_valid = 1'b1;
    step();
    check("t5_src0", 32'(o_src), 32'(exp5[0]));
    a_valid = 1'b1; b_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      step();
      check("t5_src", 32'(o_src), 32'(exp5[i]));
    end
    a_valid = 1'b0; b_valid = 1'b1;
    step();
    check("t5_src3", 32'(o_src), 32'(exp5[3]));
    a_valid = 1'b1;
    for (int i = 4; i < 8; i++) begin
      step();
      check("t5_src", 32'(o_src), 32'(exp5[i]));
    end

    // Narrow counter wrap and clr priority
    a_valid = 1'b0; b_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; a_valid = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 18) clr = 1'b1;
      step();
      if (k == 15) check("t6_cnt_15", 32'(cnt_a4), 32'd15);
      if (k == 16) check("t6_cnt_wrap", 32'(cnt_a4), 32'd0);
      if (k == 17) check("t6_cnt_17", 32'(cnt_a4), 32'd1);
      if (k == 18) check("t6_cnt_clr", 32'(cnt_a4), 32'd0);
    end
    clr = 1'b0; a_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
